// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int POLICY_DROP_NEW  = 0;
    localparam int POLICY_OVERWRITE = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x DATA_W storage for param_sync_fifo.
// Read port is registered by default, asynchronous under FIFO_FWFT_EN.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

`ifdef FIFO_FWFT_EN
    logic unused_ok;
    assign unused_ok = ^{rst_n, re};
    assign rdata = mem_q[raddr];
`else
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Old contents are read when a write hits the same address.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with overflow policy, level and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int OVERWRITE = 1,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam bit            OVW_POL = (OVERWRITE == POLICY_OVERWRITE);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AEMPTY_TH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rvld_q, rvld_d;

    logic rd_ok, push, ovw, inc;

    always_comb begin
        rd_ok = rd_en & ~empty_q;
        // A full FIFO still accepts a write when a pop frees the slot.
        push  = wr_en & (~full_q | rd_en | OVW_POL);
        ovw   = wr_en & full_q & ~rd_en & OVW_POL;
        inc   = push & ~ovw;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push)          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_ok || ovw)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        level_d = level_q + {{ADDR_W{1'b0}}, inc}
                          - {{ADDR_W{1'b0}}, rd_ok};

        empty_d  = (level_d == '0);
        full_d   = (level_d == DEPTH_L);
        afull_d  = (level_d >= AF_L);
        aempty_d = (level_d <= AE_L);

        ovf_d  = (wr_en & full_q & ~rd_en) | (ovf_q & ~clr_err);
        unf_d  = (rd_en & empty_q) | (unf_q & ~clr_err);
        rvld_d = rd_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvld_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvld_q   <= rvld_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef FIFO_FWFT_EN
    logic unused_rvld;
    assign unused_rvld = rvld_q;
    assign rd_valid    = ~empty_q;
`else
    assign rd_valid    = rvld_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
